// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the register-file write-back port arbiter.
// Widths, requester ids and the buffered write entry.
`timescale 1ns/1ps
package wb_pkg;

  localparam int NREG     = 32;
  localparam int DW       = 64;
  localparam int AW       = 5;
  localparam int XZR_ADDR = 31;

  typedef enum logic {
    REQ_EX  = 1'b0,
    REQ_MEM = 1'b1
  } wb_req_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_port_arbiter_if.sv
// Write-back requester / register-file side bundle.
// Requester 0 is the ALU result, requester 1 the load result.
`timescale 1ns/1ps
interface wb_port_arbiter_if #(
  parameter int NREG = 32,
  parameter int DW   = 64,
  parameter int AW   = 5
);

  logic                   flush;
  logic [1:0]             req_valid;
  logic [1:0][AW-1:0]     req_addr;
  logic [1:0][DW-1:0]     req_data;
  logic [1:0]             req_ready;
  logic [NREG-1:0]        wr_en;
  logic [DW-1:0]          wr_data;
  logic                   busy;

  modport master (
    output flush,
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready,
    input  wr_en,
    input  wr_data,
    input  busy
  );

  modport slave (
    input  flush,
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready,
    output wr_en,
    output wr_data,
    output busy
  );

endinterface

// File: rtl/wb_decoder.sv
// Register address to one-hot write-enable decoder.
// Output is all zero when en is low.
`timescale 1ns/1ps
module wb_decoder #(
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic            en,
  input  logic [AW-1:0]   addr,
  output logic [NREG-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      onehot[i] = en && (addr == AW'(i));
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the single register-file write port between the ALU
// and load write-back paths, one holding buffer per requester.
`timescale 1ns/1ps
module wb_port_arbiter
  import wb_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  wb_port_arbiter_if.slave bus
);

  wb_entry_t       buf_q [2];
  logic [1:0]      full_q;
  wb_req_t         last_q;
  logic [NREG-1:0] wr_en_q;
  logic [DW-1:0]   wr_data_q;

  logic [1:0]      grant;
  logic [1:0]      accept;
  logic [1:0]      xzr;
  logic            both;
  logic            same;
  logic            issue;
  wb_entry_t       gsel;
  logic [NREG-1:0] dec;

  assign both = &full_q;
  assign same = both && (buf_q[0].addr == buf_q[1].addr);

  // Same destination: the load is the older instruction, so it goes first.
  always_comb begin
    grant = '0;
    unique case (1'b1)
      same:          grant = 2'b10;
      both && !same: grant = (last_q == REQ_MEM) ? 2'b01 : 2'b10;
      default:       grant = full_q;
    endcase
  end

  always_comb begin
    gsel = buf_q[0];
    if (grant[1]) gsel = buf_q[1];
  end

  assign issue = (|grant) && !bus.flush;

  always_comb begin
    xzr    = '0;
    accept = '0;
    for (int i = 0; i < 2; i++) begin
      xzr[i]    = bus.req_addr[i] == AW'(XZR_ADDR);
      accept[i] = bus.req_valid[i] && bus.req_ready[i]
                  && !xzr[i] && !bus.flush;
    end
  end

  wb_decoder #(
    .AW   (AW),
    .NREG (NREG)
  ) u_dec (
    .en     (issue),
    .addr   (gsel.addr),
    .onehot (dec)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q   <= '0;
      wr_data_q <= '0;
      last_q    <= REQ_MEM;
    end else begin
      wr_en_q <= dec;
      if (issue) begin
        wr_data_q <= gsel.data;
        last_q    <= grant[1] ? REQ_MEM : REQ_EX;
      end
    end
  end

  // A refill at the draining edge keeps the buffer full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q <= '0;
      for (int i = 0; i < 2; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (bus.flush) begin
          full_q[i] <= 1'b0;
        end else if (accept[i]) begin
          full_q[i]     <= 1'b1;
          buf_q[i].addr <= bus.req_addr[i];
          buf_q[i].data <= bus.req_data[i];
        end else if (grant[i]) begin
          full_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.req_ready = ~full_q | grant;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = (|full_q) || (|wr_en_q);

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for the write-back port arbiter: directed
// scenarios followed by randomized traffic with flushes.
`timescale 1ns/1ps
module tb_wb_port_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  wb_port_arbiter_if #(.NREG(NREG), .DW(DW), .AW(AW)) bif ();

  wb_port_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bif)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  wb_entry_t   expq[$];
  bit          pend[2];
  wb_entry_t   pent[2];
  int          last   = 1;
  bit          issued = 1'b0;
  logic [63:0] shadow [32];

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  initial begin
    wb_entry_t e;
    int idx;
    forever begin
      @(posedge clk);
      #1;
      if (bif.wr_en != '0) begin
        check("wr_en_onehot", 64'($countones(bif.wr_en)), 64'd1);
        idx = 0;
        for (int i = 0; i < NREG; i++) if (bif.wr_en[i]) idx = i;
        if (expq.size() == 0) begin
          check("unexpected_write", 64'(bif.wr_en), 64'd0);
        end else begin
          e = expq.pop_front();
          check("wr_addr", 64'(idx), 64'(e.addr));
          check("wr_data", bif.wr_data, e.data);
        end
        shadow[idx] = bif.wr_data;
      end else if (expq.size() != 0) begin
        e = expq.pop_front();
        check("missing_write", 64'(bif.wr_en), 64'd1 << e.addr);
      end
    end
  end

  // One clock cycle of stimulus; entered and left at a falling edge.
  task automatic cycle(input bit [1:0] v,
                       input logic [4:0] a0, input logic [63:0] d0,
                       input logic [4:0] a1, input logic [63:0] d1,
                       input bit fl);
    int g;
    bit [1:0] rdy;
    logic [4:0] a [2];
    logic [63:0] d [2];
    a[0] = a0; a[1] = a1;
    d[0] = d0; d[1] = d1;
    bif.req_valid   = v;
    bif.req_addr[0] = a0;
    bif.req_addr[1] = a1;
    bif.req_data[0] = d0;
    bif.req_data[1] = d1;
    bif.flush       = fl;
    check("busy", 64'(bif.busy), 64'(pend[0] | pend[1] | issued));
    g = -1;
    if (pend[0] && pend[1])
      g = (pent[0].addr == pent[1].addr) ? 1 : ((last == 1) ? 0 : 1);
    else if (pend[0]) g = 0;
    else if (pend[1]) g = 1;
    rdy[0] = !pend[0] || (g == 0);
    rdy[1] = !pend[1] || (g == 1);
    check("req_ready", 64'(bif.req_ready), 64'(rdy));
    if (!fl && g >= 0) expq.push_back(pent[g]);
    @(posedge clk);
    if (fl) begin
      pend[0] = 1'b0;
      pend[1] = 1'b0;
      issued  = 1'b0;
    end else begin
      issued = (g >= 0);
      if (g >= 0) begin
        pend[g] = 1'b0;
        last    = g;
      end
      for (int i = 0; i < 2; i++) begin
        if (v[i] && rdy[i] && a[i] != 5'(XZR_ADDR)) begin
          pend[i] = 1'b1;
          pent[i] = '{addr: a[i], data: d[i]};
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(2'b00, 5'd0, 64'd0, 5'd0, 64'd0, 1'b0);
  endtask

  initial begin
    bif.flush     = 1'b0;
    bif.req_valid = '0;
    bif.req_addr  = '0;
    bif.req_data  = '0;
    for (int i = 0; i < 32; i++) shadow[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_wr_en", 64'(bif.wr_en), 64'd0);
    check("rst_wr_data", bif.wr_data, 64'd0);
    check("rst_ready", 64'(bif.req_ready), 64'd3);
    check("rst_busy", 64'(bif.busy), 64'd0);
    reset_n = 1'b1;

    cycle(2'b01, 5'd5, 64'hA5, 5'd0, 64'd0, 1'b0);
    idle(3);
    check("single_reg5", shadow[5], 64'hA5);
    cycle(2'b10, 5'd0, 64'd0, 5'd1, 64'h11, 1'b0);
    idle(2);

    cycle(2'b11, 5'd3, 64'h33, 5'd7, 64'h77, 1'b0);
    idle(3);

    cycle(2'b11, 5'd9, 64'd1, 5'd9, 64'd2, 1'b0);
    idle(3);
    check("same_addr_reg9", shadow[9], 64'd1);

    cycle(2'b10, 5'd0, 64'd0, 5'd31, 64'hFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("xzr_no_write", 64'(bif.wr_en), 64'd0);
      idle(1);
    end

    cycle(2'b11, 5'd4, 64'h44, 5'd6, 64'h66, 1'b0);
    cycle(2'b11, 5'd8, 64'h88, 5'd10, 64'hAA, 1'b1);
    check("flush_no_pulse", 64'(bif.wr_en), 64'd0);
    check("flush_busy", 64'(bif.busy), 64'd0);
    idle(2);

    cycle(2'b01, 5'd12, 64'hC0DE, 5'd0, 64'd0, 1'b0);
    idle(1);
    check("pre_reset_pulse", 64'(bif.wr_en), 64'd1 << 12);
    reset_n = 1'b0;
    #1;
    check("async_rst_wr_en", 64'(bif.wr_en), 64'd0);
    check("async_rst_ready", 64'(bif.req_ready), 64'd3);
    check("async_rst_busy", 64'(bif.busy), 64'd0);
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    issued  = 1'b0;
    last    = 1;
    @(negedge clk);
    reset_n = 1'b1;

    for (int n = 0; n < 400; n++) begin
      cycle(2'($urandom_range(0, 3)),
            5'($urandom_range(0, 31)), {$urandom, $urandom},
            5'($urandom_range(0, 31)), {$urandom, $urandom},
            $urandom_range(0, 19) == 0);
    end
    idle(4);
    check("scoreboard_empty", 64'(expq.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
